obj_serializer: RTL
===================

OBJ_SERIALIZER -- requirements
Module: obj_serializer

Interface
REQ-001 Parameter GFX_W, default 8: graphics register width, bits per object copy.
REQ-002 Parameter LINE_W, default 160: visible pixels per line, the position counter modulus.
REQ-003 Parameter CNT_W, default 8: position counter width; SHALL satisfy 2^CNT_W >= LINE_W.
REQ-004 Port clk  in  1: single system clock; all state changes on its rising edge.
REQ-005 Port rst_n  in  1: asynchronous, active-low reset.
REQ-006 Port pix_en  in  1: pixel-clock enable, one pulse per visible pixel.
REQ-007 Port hm_pulse  in  1: horizontal-motion extra tick, one per clock when asserted.
REQ-008 Port resp  in  1: reset-position strobe.
REQ-009 Port gfx_wr  in  1: load gfx_data into the new graphics register.
REQ-010 Port gfx_data  in  GFX_W: graphics pattern.
REQ-011 Port gfx_copy  in  1: copy the new graphics register into the old graphics register.
REQ-012 Port vdel  in  1: vertical delay; 1 displays old, 0 displays new.
REQ-013 Port refl  in  1: reflect; 1 shows LSB first, 0 shows MSB first.
REQ-014 Port size  in  3: copy/scale mode.
REQ-015 Port pixel_on  out  1: registered object pixel.
REQ-016 Port pos_cnt  out  CNT_W: current position counter.

Function
REQ-017 tick = pix_en OR hm_pulse; both high in one cycle SHALL count one tick only.
REQ-018 On tick, pos_cnt SHALL advance by 1 and wrap from LINE_W-1 to 0.
REQ-019 resp SHALL set pos_cnt to 0 and override a same-cycle tick; no start decode occurs in that cycle.
REQ-020 On tick, start decode SHALL use pos_cnt before increment. Copy offsets and scale S by size:
  - 0: {0}, S=1
  - 1: {0,16}, S=1
  - 2: {0,32}, S=1
  - 3: {0,16,32}, S=1
  - 4: {0,64}, S=1
  - 5: {0}, S=2
  - 6: {0,32,64}, S=1
  - 7: {0}, S=4
REQ-021 The serializer SHALL have states IDLE and SHIFT, with bit index bidx (0..GFX_W-1) and scale counter scnt (0..S-1).
REQ-022 A start on tick SHALL set state SHIFT, bidx=0, scnt=0, including when already in SHIFT (restart).
REQ-023 In SHIFT, each non-start tick SHALL increment scnt; when scnt=S-1, scnt SHALL go to 0 and bidx SHALL increment.
REQ-024 When bidx=GFX_W-1 and scnt=S-1, the next non-start tick SHALL return the serializer to IDLE.
REQ-025 The serializer SHALL hold its state on cycles without a tick.
REQ-026 pixel_on SHALL update only on tick edges; it SHALL be 0 in IDLE, otherwise gfx_sel[refl ? bidx : GFX_W-1-bidx] for the post-edge state. Latency: the first pixel is visible the cycle after the start tick.
REQ-027 gfx_sel SHALL be vdel ? gfx_old : gfx_new, sampled at the tick edge.
REQ-028 gfx_wr SHALL load gfx_new.
REQ-029 gfx_copy SHALL set gfx_old to the pre-edge gfx_new; gfx_wr and gfx_copy together SHALL leave gfx_old with the pre-edge gfx_new.
REQ-030 A change of size mid-copy SHALL take effect for scale at the next tick; scnt is not cleared, and scnt >= new S SHALL be treated as S-1.
REQ-031 resp SHALL NOT abort an active serializer.

Reset
REQ-032 rst_n low SHALL asynchronously clear pos_cnt, gfx_new, gfx_old, bidx, scnt and pixel_on, and set the state to IDLE.
REQ-033 After rst_n deasserts, the first tick SHALL start copy 0, because pos_cnt=0.
REQ-034 Reset asserted mid-copy SHALL drop pixel_on to 0 immediately.

Verification
REQ-035 Write gfx_data=8'hA5, size=0, refl=0, vdel=0, resp, then 8 pix_en -> pixel_on sequence 1,0,1,0,0,1,0,1, then 0.
REQ-036 Same pattern with refl=1 -> 1,0,1,0,0,1,0,1 (palindrome check); pattern 8'h80 with refl=1 -> pixel_on high only on the 8th pixel.
REQ-037 size=3, gfx=8'hFF, 160 pix_en from pos 0 -> pixel_on high at pos 0-7, 16-23, 32-39 only; pos_cnt wraps 159 -> 0.
REQ-038 size=7, gfx=8'h80 -> pixel_on high for exactly 4 consecutive pixels, then low for 28.
REQ-039 vdel=1, gfx_wr 8'hFF, no gfx_copy -> pixel_on stays 0; after gfx_copy -> 8 high pixels.
REQ-040 hm_pulse with pix_en high for 5 cycles -> pos_cnt +5, not +10; resp with pix_en high -> pos_cnt=0 next cycle; rst_n low mid-copy -> pixel_on=0 with no clock edge.

Source files
------------

// File: rtl/obj_serializer.sv
// obj_serializer: horizontal object position counter with copy/scale decode and graphics shift-out.
module obj_serializer #(
  parameter int GFX_W  = 8,
  parameter int LINE_W = 160,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic             hm_pulse,
  input  logic             resp,
  input  logic             gfx_wr,
  input  logic [GFX_W-1:0] gfx_data,
  input  logic             gfx_copy,
  input  logic             vdel,
  input  logic             refl,
  input  logic [2:0]       size,
  output logic             pixel_on,
  output logic [CNT_W-1:0] pos_cnt
);
  localparam int BW = GFX_W > 1 ? $clog2(GFX_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    bidx_q, bidx_d;
  logic [1:0]       scnt_q, scnt_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [GFX_W-1:0] gfx_new_q, gfx_old_q, gfx_sel;
  logic             pix_q, pix_d;
  logic             tick, hit, start, last_bit;
  logic [1:0]       s_max, scnt_eff;
  logic [31:0]      pos_w;

  assign tick     = pix_en | hm_pulse;
  assign pos_w    = 32'(pos_q);
  assign hit      = (pos_w == 32'd0)
                  | ((size == 3'd1 || size == 3'd3) && pos_w == 32'd16)
                  | ((size == 3'd2 || size == 3'd3 || size == 3'd6) && pos_w == 32'd32)
                  | ((size == 3'd4 || size == 3'd6) && pos_w == 32'd64);
  assign start    = tick & ~resp & hit;
  assign s_max    = size == 3'd5 ? 2'd1 : size == 3'd7 ? 2'd3 : 2'd0;
  // A size change mid-copy can leave scnt beyond the new scale; clamp it.
  assign scnt_eff = scnt_q > s_max ? s_max : scnt_q;
  assign last_bit = bidx_q == BW'(GFX_W-1);
  assign gfx_sel  = vdel ? gfx_old_q : gfx_new_q;
  assign pos_d    = resp ? '0 : !tick ? pos_q : pos_q == CNT_W'(LINE_W-1) ? '0 : pos_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bidx_q    <= '0;
      scnt_q    <= '0;
      pos_q     <= '0;
      gfx_new_q <= '0;
      gfx_old_q <= '0;
      pix_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bidx_q    <= bidx_d;
      scnt_q    <= scnt_d;
      pos_q     <= pos_d;
      gfx_new_q <= gfx_wr ? gfx_data : gfx_new_q;
      gfx_old_q <= gfx_copy ? gfx_new_q : gfx_old_q;
      pix_q     <= pix_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    scnt_d  = scnt_q;
    if (start) begin
      state_d = SHIFT;
      bidx_d  = '0;
      scnt_d  = '0;
    end else if (tick && state_q == SHIFT) begin
      scnt_d  = scnt_eff == s_max ? 2'd0 : 2'(scnt_eff + 2'd1);
      bidx_d  = scnt_eff != s_max ? bidx_q : last_bit ? '0 : bidx_q + BW'(1);
      state_d = scnt_eff == s_max && last_bit ? IDLE : SHIFT;
    end
  end

  always_comb begin
    pix_d = !tick ? pix_q
          : state_d == SHIFT && gfx_sel[refl ? bidx_d : BW'(GFX_W-1) - bidx_d];
  end

  assign pixel_on = pix_q;
  assign pos_cnt  = pos_q;
endmodule
